// File: rtl/conv_host_mem.sv
// conv_host_mem: host-side memory for the CONV accelerator.
// Holds the image, L0 and L1 memories. Loads the image, hands it to CONV, then dumps L0 and L1.
module conv_host_mem #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 20,
  parameter int L1_DEPTH = 1024,
  parameter logic [2:0] CSEL_L0 = 3'b001,
  parameter logic [2:0] CSEL_L1 = 3'b011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ready,
  input  logic              busy,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] idata,
  input  logic              cwr,
  input  logic [ADDR_W-1:0] caddr_wr,
  input  logic [DATA_W-1:0] cdata_wr,
  input  logic              crd,
  input  logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_rd,
  input  logic [2:0]        csel,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_layer,
  output logic              rd_last,
  output logic              done,
  output logic              err
);
  localparam int L1_AW = $clog2(L1_DEPTH);
  localparam int IMG_D = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, LOAD, HANDOFF, RUN, DUMP, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] img [IMG_D];
  logic [DATA_W-1:0] l0 [IMG_D];
  logic [DATA_W-1:0] l1 [L1_DEPTH];
  logic [ADDR_W-1:0] cnt;
  logic              layer;
  logic              sel_l0, sel_l1, l1_oob, last;

  assign sel_l0 = csel == CSEL_L0;
  assign sel_l1 = csel == CSEL_L1;
  assign l1_oob = caddr_wr[ADDR_W-1:L1_AW] != '0;
  assign last = layer ? cnt == ADDR_W'(L1_DEPTH - 1) : &cnt;
  assign idata = img[iaddr];
  assign cdata_rd = crd && sel_l0 ? l0[caddr_rd] : crd && sel_l1 ? l1[caddr_rd[L1_AW-1:0]] : '0;
  // dump outputs follow the registered counter, so they hold while rd_ready is low
  assign rd_data = !rd_valid ? '0 : layer ? l1[cnt[L1_AW-1:0]] : l0[cnt];
  assign rd_layer = rd_valid & layer;
  assign rd_last = rd_valid & last;

  always_ff @(posedge clk) begin
    if (reset && ld_valid && ld_ready) img[cnt] <= ld_data;
    if (cwr && sel_l0) l0[caddr_wr] <= cdata_wr;
    if (cwr && sel_l1 && !l1_oob) l1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ld_ready <= 1'b0;
      ready <= 1'b0;
      rd_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
      layer <= 1'b0;
    end else begin
      err <= err | (cwr & crd) | ((cwr | crd) & !sel_l0 & !sel_l1) | (cwr & sel_l1 & l1_oob);
      case (state)
        IDLE, DONE: if (start) begin
          state <= LOAD;
          ld_ready <= 1'b1;
          done <= 1'b0;
          cnt <= '0;
        end
        LOAD: if (ld_valid) begin
          cnt <= cnt + ADDR_W'(1);
          if (&cnt) begin
            state <= HANDOFF;
            ld_ready <= 1'b0;
            ready <= 1'b1;
          end
        end
        HANDOFF: if (busy) begin
          state <= RUN;
          ready <= 1'b0;
        end
        RUN: if (!busy) begin
          state <= DUMP;
          rd_valid <= 1'b1;
          cnt <= '0;
          layer <= 1'b0;
        end
        DUMP: if (rd_ready) begin
          cnt <= last ? '0 : cnt + ADDR_W'(1);
          if (last) begin
            layer <= 1'b1;
            if (layer) begin
              state <= DONE;
              rd_valid <= 1'b0;
              done <= 1'b1;
              layer <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_host_mem.sv
// tb_conv_host_mem: directed bench for conv_host_mem with a small L0/L1/image model.
module tb_conv_host_mem;
  logic        clk = 0, reset = 0, start = 0, ld_valid = 0, busy = 0;
  logic        cwr = 0, crd = 0, rd_ready = 0;
  logic [19:0] ld_data = '0, cdata_wr = '0;
  logic [11:0] iaddr = '0, caddr_wr = '0, caddr_rd = '0;
  logic [2:0]  csel = 3'b001;
  logic        ld_ready, ready, rd_valid, rd_layer, rd_last, done, err;
  logic [19:0] idata, cdata_rd, rd_data;
  logic [19:0] l0m [4096];
  logic [19:0] l1m [1024];
  int checks = 0, failures = 0;

  conv_host_mem dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd), .csel(csel), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_layer(rd_layer), .rd_last(rd_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] img_val(input int mode, input int i);
    return mode != 0 ? 20'(i) ^ 20'hAAAAA : 20'(i);
  endfunction

  task automatic do_load(input int mode);
    int acc = 0, cyc = 0;
    logic a;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("ld_ready_up", ld_ready, 1);
    ld_valid = 1;
    while (acc < 4096 && cyc < 5000) begin
      ld_data = img_val(mode, acc);
      a = ld_ready;
      @(negedge clk);
      if (a) acc++;
      cyc++;
    end
    ld_valid = 0;
    chk("ld_cycles", cyc, 4096);
    chk("ld_ready_drop", ld_ready, 0);
    chk("ready_rise", ready, 1);
    iaddr = 12'h7FF;
    #1 chk("idata_7ff", idata, img_val(mode, 12'h7FF));
  endtask

  task automatic read_l(input logic [2:0] sel, input int addr, input logic [19:0] exp, input string tag);
    crd = 1;
    csel = sel;
    caddr_rd = 12'(addr);
    #1 chk(tag, cdata_rd, exp);
    @(negedge clk);
    crd = 0;
  endtask

  task automatic write_l(input logic [2:0] sel, input int addr, input logic [19:0] d);
    cwr = 1;
    csel = sel;
    caddr_wr = 12'(addr);
    cdata_wr = d;
    @(negedge clk);
    cwr = 0;
  endtask

  task automatic dump(input int stop_at);
    int layer_i = 0, idx = 0, k = 0, cyc = 0;
    logic bad = 0, adv;
    logic [3:0] pat = 4'b1001;
    logic [31:0] got, expv;
    logic [19:0] e;
    while (layer_i < 2 && cyc < 20000) begin
      if (stop_at >= 0 && idx == stop_at) break;
      rd_ready = stop_at >= 0 ? 1'b1 : pat[k % 4];
      e = layer_i != 0 ? l1m[idx] : l0m[idx];
      got = {9'd0, rd_valid, rd_layer, rd_last, rd_data};
      expv = {9'd0, 1'b1, layer_i[0], idx == (layer_i != 0 ? 1023 : 4095), e};
      if (!bad) begin
        chk($sformatf("dump_l%0d_%0d", layer_i, idx), got, expv);
        bad = got !== expv;
      end
      if (layer_i == 0 && idx == 4095) chk("l0_last", rd_last, 1);
      adv = rd_ready;
      k++;
      cyc++;
      @(negedge clk);
      if (adv) begin
        idx++;
        if (idx == (layer_i != 0 ? 1024 : 4096)) begin
          idx = 0;
          layer_i++;
        end
      end
    end
    rd_ready = 0;
    chk("dump_bound", cyc < 20000, 1);
  endtask

  task automatic handoff_wait;
    busy = 0;
    repeat (10) @(negedge clk);
    chk("ready_hold", ready, 1);
    busy = 1;
    @(negedge clk);
    chk("ready_fall", ready, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) l0m[i] = 20'(i * 37 + 5);
    for (int i = 0; i < 1024; i++) l1m[i] = 20'hF0000 ^ 20'(i);
    repeat (3) @(negedge clk);
    chk("rst_out", {ld_ready, ready, rd_valid, rd_layer, rd_last, done, err}, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1;
    @(negedge clk);
    do_load(0);
    handoff_wait();
    for (int i = 0; i < 4096; i++) write_l(3'b001, i, l0m[i]);
    for (int i = 0; i < 1024; i++) write_l(3'b011, i, l1m[i]);
    write_l(3'b001, 5, 20'h12345);
    l0m[5] = 20'h12345;
    read_l(3'b001, 5, 20'h12345, "l0_rd5");
    read_l(3'b011, 5, l1m[5], "l1_rd5");
    write_l(3'b011, 5, 20'h0ABCD);
    l1m[5] = 20'h0ABCD;
    read_l(3'b001, 5, 20'h12345, "l0_keep5");
    read_l(3'b011, 5, 20'h0ABCD, "l1_new5");
    chk("err_clean", err, 0);
    chk("rd_idle_run", rd_valid, 0);
    busy = 0;
    @(negedge clk);
    chk("dump_start", rd_valid, 1);
    chk("dump_first", rd_data, l0m[0]);
    dump(-1);
    chk("done_set", done, 1);
    chk("done_rdv", rd_valid, 0);
    chk("err_after_dump", err, 0);
    write_l(3'b010, 7, 20'h55555);
    chk("err_bad_csel", err, 1);
    read_l(3'b001, 7, l0m[7], "bad_csel_l0");
    read_l(3'b011, 7, l1m[7], "bad_csel_l1");
    cwr = 1; crd = 1; csel = 3'b001; caddr_wr = 12'd9; caddr_rd = 12'd9; cdata_wr = 20'h0BEEF;
    #1 chk("rw_old", cdata_rd, l0m[9]);
    @(negedge clk);
    cwr = 0;
    l0m[9] = 20'h0BEEF;
    #1 chk("rw_new", cdata_rd, 20'h0BEEF);
    crd = 0;
    reset = 0;
    @(negedge clk);
    reset = 1;
    #1 chk("err_cleared", err, 0);
    write_l(3'b011, 1024, 20'h77777);
    chk("err_l1_oob", err, 1);
    read_l(3'b011, 0, l1m[0], "l1_oob_drop");
    repeat (5) @(negedge clk);
    chk("err_sticky", err, 1);
    busy = 1;
    do_load(1);
    @(negedge clk);
    chk("ready_1cyc", ready, 0);
    busy = 0;
    @(negedge clk);
    chk("dump2_start", rd_valid, 1);
    dump(100);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("mid_rst", {ld_ready, ready, rd_valid, done, err}, 0);
    iaddr = 12'h123;
    #1 chk("img_keep", idata, img_val(1, 12'h123));
    do_load(0);
    handoff_wait();
    busy = 0;
    @(negedge clk);
    dump(-1);
    chk("done_final", done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_host_mem.md
Name: conv_host_mem

Overview:
- Responder/host end of the CONV accelerator memory interface.
- Owns the image memory and the two layer memories (L0 and L1).
- Accepts an image from a load stream, raises ready, and serves idata, cdata_rd and layer writes while CONV is busy.
- After busy falls, streams L0 then L1 contents out on a dump stream.

Parameters:
ADDR_W, 12, address width; image and L0 depth = 2**ADDR_W
DATA_W, 20, word width (signed Q4.16 data, treated as raw bits here)
L1_DEPTH, 1024, L1 (max-pool) memory depth
CSEL_L0, 3'b001, csel code selecting L0
CSEL_L1, 3'b011, csel code selecting L1

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets)
start  in  1  1-cycle pulse; begins a load (IDLE) or clears DONE
ld_valid  in  1  load-stream word valid
ld_data  in  DATA_W  image word, raster order from address 0
ld_ready  out  1  load-stream accept
ready  out  1  to CONV: image loaded
busy  in  1  from CONV
iaddr  in  ADDR_W  image read address
idata  out  DATA_W  image read data
cwr  in  1  layer write enable
caddr_wr  in  ADDR_W  layer write address
cdata_wr  in  DATA_W  layer write data
crd  in  1  layer read enable
caddr_rd  in  ADDR_W  layer read address
cdata_rd  out  DATA_W  layer read data
csel  in  3  layer select
rd_valid  out  1  dump word valid
rd_ready  in  1  dump accept
rd_data  out  DATA_W  dump word
rd_layer  out  1  0 = L0 word, 1 = L1 word
rd_last  out  1  last word of the current layer
done  out  1  dump complete, held until start
err  out  1  sticky protocol-error flag

Behaviour:
- Reset: state IDLE; ld_ready=0, ready=0, rd_valid=0, rd_data=0, rd_layer=0, rd_last=0, done=0, err=0; internal counters cleared. Memory contents are not cleared.
- Reset mid-operation aborts immediately to IDLE. Any partial load or dump is discarded.
- States: IDLE, LOAD, HANDOFF, RUN, DUMP, DONE.
- IDLE: start -> LOAD with load counter=0.
- LOAD:
  - ld_ready=1.
  - Each cycle with ld_valid & ld_ready: img[cnt] <= ld_data, cnt++.
  - On the 2**ADDR_W-th accept -> HANDOFF; ld_ready drops the next cycle.
  - ld_valid outside LOAD is ignored.
- HANDOFF:
  - ready=1 (registered) held until busy is sampled 1, then ready=0 and -> RUN.
  - busy already 1 on entry -> ready high exactly one cycle.
- RUN: waits for busy 1->0 (sampled high then low) -> DUMP with dump counter=0, layer=0.
- idata = img[iaddr]: combinational, any state, no latency. CONV registers iaddr and samples idata the following cycle.
- Layer writes:
  - In any state, cwr=1 & csel==CSEL_L0: L0[caddr_wr] <= cdata_wr on clk.
  - cwr=1 & csel==CSEL_L1: L1[caddr_wr[log2(L1_DEPTH)-1:0]] <= cdata_wr.
- Layer reads: cdata_rd is combinational. crd & CSEL_L0 -> L0[caddr_rd]; crd & CSEL_L1 -> L1[caddr_rd low bits]; otherwise 0.
- Same-cycle write and read of the same address returns the old (pre-write) value.
- err set (sticky until reset) on any of:
  - cwr & crd both high;
  - (cwr|crd) with csel not in {CSEL_L0, CSEL_L1};
  - cwr to L1 with caddr_wr >= L1_DEPTH (write is dropped).
- DUMP:
  - rd_valid=1; rd_data = current layer[cnt]; rd_layer = layer; rd_last = (cnt == depth-1).
  - Handshake rd_valid & rd_ready advances cnt.
  - While rd_ready=0, rd_data, rd_layer and rd_last hold stable.
  - After L0's last word -> layer=1, cnt=0; after L1's last word -> DONE. Dump is back-to-back, no bubble between layers.
- DONE: rd_valid=0, done=1; start -> LOAD (done=0).
- start outside IDLE/DONE is ignored.
- cwr/crd activity while not in RUN is still serviced; it is not an error.

Test Plan:
- Load ramp img[i]=i with ld_valid held 1 -> ld_ready high 4096 cycles; ready rises the cycle after the last accept; idata at iaddr=0x7FF reads 0x007FF.
- ready/busy handshake: hold busy=0 for 10 cycles after ready -> ready stays 1; raise busy -> ready=0 the next cycle; drop busy after 50 cycles -> rd_valid=1 with rd_data=L0[0].
- Write L0[5]=0x12345 with csel=001, then crd caddr_rd=5 csel=001 -> cdata_rd=0x12345; same address with csel=011 -> L1[5] contents, and L0 is unaffected.
- Dump with rd_ready toggling 1,0,0,1 -> each word transferred exactly once, data stable while stalled; 4096 L0 words then 1024 L1 words; rd_last on L0 index 4095 and L1 index 1023; done=1 afterwards.
- Protocol errors:
  - cwr=1 with csel=010 -> err=1 and no memory changes;
  - cwr to L1 at address 1024 -> err=1, write dropped;
  - err remains 1 until reset=0.
- Drive reset=0 for one cycle mid-dump at word 100 -> rd_valid=0, state IDLE, done=0; after start and a reload, memory data written earlier is still present.
